mcpu5_run_ctrl: RTL and testbench

Run controller for the MCPU5plus core.
- Owns a writable program store and loads it from a host port.
- Sequences the core through reset, then run, then stop.
- Serves instruction fetches, detects the OUT instruction and buffers output values in a small FIFO.
- Sits between the host/test harness and the core's 8-bit IO: cpu_out (address/data) and the 6-bit instruction input.

---
 rtl/mcpu5_run_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mcpu5_run_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu5_run_ctrl.sv
// Output FIFO: registered push/pop, head is visible combinationally one edge after push.
// Push when full without a pop is dropped and flagged on drop_o; clr_i flushes the pointers.
module mcpu5_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr_i,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_rdy_i,
    output logic [W-1:0] head_dat_o,
    output logic         head_vld_o,
    output logic         drop_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    logic         empty, full, pop_ok, push_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop_rdy_i && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = push_vld_i && (!full || pop_ok);
    assign drop_o  = push_vld_i && full && !pop_ok;

    assign head_dat_o = mem_q[rd_q[AW-1:0]];
    assign head_vld_o = !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q[AW-1:0]] <= push_dat_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_ok) rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// Run controller for MCPU5plus: program store, reset/run/stop sequencing, OUT capture FIFO.
// Instruction fetch has one clock of latency; OUT values are dropped (overflow) when the FIFO is full.
module mcpu5_run_ctrl #(
    parameter int       ADDR_W     = 8,
    parameter int       CYC_W      = 16,
    parameter int       MAX_CYCLES = 10000,
    parameter int       RST_CYCLES = 2,
    parameter bit [5:0] RST_INST   = 6'b111001,
    parameter bit [5:0] OUT_OPCODE = 6'b111011,
    parameter int       FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [5:0]        load_data,
    input  logic [7:0]        cpu_out,
    output logic [5:0]        cpu_inst,
    output logic              cpu_reset,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [CYC_W-1:0]  cycle_count
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;
    logic [5:0]        cpu_inst_q, cpu_inst_d;
    logic              cpu_reset_q, busy_q, done_q;
    logic              fifo_clr, out_push, fifo_drop, idle_or_done;
    logic [5:0]        prog_mem [2**ADDR_W];
    logic [5:0]        fetch_dat;

    assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    assign fetch_dat    = prog_mem[cpu_out[ADDR_W-1:0]];
    assign out_push     = (state_q == S_RUN) && (cpu_inst_q == OUT_OPCODE);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cyc_d     = cyc_q;
        timeout_d = timeout_q;
        fifo_clr  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RESET;
                    rst_cnt_d = '0;
                    cyc_d     = '0;
                    timeout_d = 1'b0;
                    fifo_clr  = 1'b1;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_RUN;
                else                                    rst_cnt_d = rst_cnt_q + 1'b1;
            end
            S_RUN: begin
                cyc_d = cyc_q + CYC_W'(1);
                // The cycle limit wins over a simultaneous stop so the timeout is never hidden.
                if (cyc_d == CYC_W'(MAX_CYCLES)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else if (stop) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        overflow_d = fifo_clr ? 1'b0 : (overflow_q | fifo_drop);
        cpu_inst_d = (state_d == S_RUN) ? fetch_dat : RST_INST;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            cyc_q       <= '0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            cpu_inst_q  <= RST_INST;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cyc_q       <= cyc_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            cpu_inst_q  <= cpu_inst_d;
            cpu_reset_q <= (state_d != S_RUN);
            busy_q      <= (state_d == S_RESET) || (state_d == S_RUN);
            done_q      <= (state_d == S_DONE);
        end
    end

    // Program store survives reset; the host may only write while the core is parked.
    always_ff @(posedge clk) begin
        if (load_we && idle_or_done) prog_mem[load_addr] <= load_data;
    end

    mcpu5_out_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (fifo_clr),
        .push_vld_i (out_push),
        .push_dat_i (cpu_out),
        .pop_rdy_i  (out_ready),
        .head_dat_o (out_data),
        .head_vld_o (out_valid),
        .drop_o     (fifo_drop)
    );

    assign cpu_inst    = cpu_inst_q;
    assign cpu_reset   = cpu_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign overflow    = overflow_q;
    assign cycle_count = cyc_q;
endmodule

// File: tb/tb_mcpu5_run_ctrl.sv
// Directed bench for mcpu5_run_ctrl with MAX_CYCLES shortened to 20.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_mcpu5_run_ctrl;
    logic       clk;
    logic       reset_n;
    logic       start, stop, load_we, out_ready;
    logic [7:0] load_addr;
    logic [5:0] load_data;
    logic [7:0] cpu_out;
    logic [5:0] cpu_inst;
    logic       cpu_reset, out_valid, busy, done, timeout, overflow;
    logic [7:0] out_data;
    logic [15:0] cycle_count;

    int total = 0;
    int bad   = 0;

    mcpu5_run_ctrl #(.MAX_CYCLES(20)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .cpu_out     (cpu_out),
        .cpu_inst    (cpu_inst),
        .cpu_reset   (cpu_reset),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .overflow    (overflow),
        .cycle_count (cycle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Program: mem[0]=000001, everything else OUT. Stops in the 7th RUN cycle.
    task automatic run_pattern(input logic with_load);
        cpu_out   = 8'h00;
        out_ready = 1'b1;
        start     = 1'b1;
        if (with_load) begin
            load_we   = 1'b1;
            load_addr = 8'h00;
            load_data = 6'b000001;
        end
        step();
        start   = 1'b0;
        load_we = 1'b0;
        chk("rp_busy", busy, 1);
        chk("rp_cnt_clr", cycle_count, 0);
        chk("rp_to_clr", timeout, 0);
        chk("rp_ovf_clr", overflow, 0);
        chk("rp_fifo_clr", out_valid, 0);
        step();
        step();
        chk("rp_fetch0", cpu_inst, 6'b000001);
        cpu_out = 8'h01;
        step();
        chk("rp_fetch1", cpu_inst, 6'b111011);
        chk("rp_nopush", out_valid, 0);
        for (int k = 1; k <= 6; k++) begin
            cpu_out = 8'h50 + 8'(k);
            if (k == 6) stop = 1'b1;
            step();
        end
        stop = 1'b0;
        chk("rp_done", done, 1);
        chk("rp_cnt7", cycle_count, 7);
        chk("rp_to", timeout, 0);
        chk("rp_vld", out_valid, 1);
        chk("rp_dat", out_data, 8'h56);
        chk("rp_ovf", overflow, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;
        cpu_out   = '0;
        out_ready = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_inst", cpu_inst, 6'b111001);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cycle_count, 0);
        chk("rst_to", timeout, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        step();

        // Single OUT: address 0 holds OUT, the rest are 000001
        for (int i = 0; i < 256; i++) begin
            load_we   = 1'b1;
            load_addr = 8'(i);
            load_data = (i == 0) ? 6'b111011 : 6'b000001;
            step();
        end
        load_we = 1'b0;
        start   = 1'b1;
        cpu_out = 8'h00;
        step();
        start = 1'b0;
        chk("t2_busy", busy, 1);
        chk("t2_rst_c1", cpu_reset, 1);
        chk("t2_done0", done, 0);
        step();
        chk("t2_rst_c2", cpu_reset, 1);
        chk("t2_inst_rst", cpu_inst, 6'b111001);
        step();
        chk("t2_run_rst", cpu_reset, 0);
        chk("t2_inst_out", cpu_inst, 6'b111011);
        chk("t2_cnt0", cycle_count, 0);
        cpu_out = 8'h2A;
        step();
        chk("t2_vld", out_valid, 1);
        chk("t2_dat", out_data, 8'h2A);
        chk("t2_cnt1", cycle_count, 1);
        chk("t2_inst_next", cpu_inst, 6'b000001);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_busy0", busy, 0);
        chk("t2_cnt2", cycle_count, 2);
        chk("t2_to", timeout, 0);
        chk("t2_cpu_reset", cpu_reset, 1);

        // OUT every cycle, consumer stalled
        for (int i = 0; i < 256; i++) begin
            load_we   = 1'b1;
            load_addr = 8'(i);
            load_data = 6'b111011;
            step();
        end
        load_we = 1'b0;
        cpu_out = 8'h00;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("t3_fifo_clr", out_valid, 0);
        step();
        step();
        for (int k = 1; k <= 5; k++) begin
            cpu_out = 8'hA0 + 8'(k);
            step();
            if (k == 4) chk("t3_ovf_at4", overflow, 0);
        end
        chk("t3_ovf_at5", overflow, 1);
        chk("t3_cnt5", cycle_count, 5);
        stop    = 1'b1;
        cpu_out = 8'hA6;
        step();
        stop = 1'b0;
        chk("t3_done", done, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t3_pop_vld", out_valid, 1);
            chk("t3_pop_dat", out_data, 8'hA0 + 8'(k));
            step();
        end
        chk("t3_empty", out_valid, 0);
        out_ready = 1'b0;

        // Timeout after 20 RUN cycles; start mid-run is ignored
        cpu_out = 8'h00;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("t4_ovf_clr", overflow, 0);
        step();
        step();
        for (int k = 1; k <= 19; k++) begin
            if (k == 5) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk("t4_cnt19", cycle_count, 19);
        chk("t4_busy19", busy, 1);
        chk("t4_to19", timeout, 0);
        step();
        chk("t4_done", done, 1);
        chk("t4_to", timeout, 1);
        chk("t4_cnt20", cycle_count, 20);
        chk("t4_cpu_reset", cpu_reset, 1);
        chk("t4_inst", cpu_inst, 6'b111001);
        chk("t4_ovf", overflow, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4_hold_cnt", cycle_count, 20);
        chk("t4_hold_done", done, 1);

        // Stop with a simultaneous OUT push; start together with a program write
        run_pattern(1'b1);

        // Asynchronous reset mid-run, then an identical rerun
        cpu_out = 8'h00;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        cpu_out = 8'h01;
        step();
        cpu_out = 8'h51;
        step();
        step();
        chk("t6_pre_vld", out_valid, 1);
        chk("t6_pre_cnt", cycle_count, 3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_cpu_reset", cpu_reset, 1);
        chk("t6_inst", cpu_inst, 6'b111001);
        chk("t6_vld", out_valid, 0);
        chk("t6_dat", out_data, 0);
        chk("t6_cnt", cycle_count, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_to", timeout, 0);
        step();
        reset_n = 1'b1;
        step();
        chk("t6_idle_busy", busy, 0);
        run_pattern(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
